// File: rtl/systolic_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// systolic_ctrl_pkg
// Shared types and constants for the job controller that sits in front of
// the 4x4 systolic matrix multiplier.
//   matrix_t    : 4x4 matrix of 8-bit elements, indexed [row][col]
//   state_t     : job controller FSM states
//   MUL_LATENCY : cycles from the multiplier launch pulse to validResult
//   WAIT_CNT_W  : width of the result wait counter
//   idx_width() : index width for an N-entry one-hot vector (minimum 1)
// ---------------------------------------------------------------------------
package systolic_ctrl_pkg;

    typedef logic [3:0][3:0][7:0] matrix_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int MUL_LATENCY = 11;
    localparam int WAIT_CNT_W  = 5;

    // A single requester still needs a one-bit index so that ports never
    // collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_job_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search begins at the
// requester just after the most recent grant and wraps around, so the
// requester granted last has the lowest priority next time.
//   req   : per-requester request vector
//   last  : index of the most recently granted requester
//   grant : one-hot grant, or all zeros when nobody requests
// ---------------------------------------------------------------------------
module rr_arbiter
    import systolic_ctrl_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant
);

    logic found;
    int   idx;

    // Walk the N candidates starting one past the last winner. The first
    // requester found wins; the found flag keeps the result one-hot.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_job_arbiter.sv
// ---------------------------------------------------------------------------
// systolic_job_arbiter
// Job controller in front of the 4x4 systolic multiplier. Picks one of
// NUM_REQ requesters round-robin, captures its operands, fires a one-cycle
// launch pulse, waits for the first result (or gives up after TIMEOUT wait
// cycles) and returns the product to the requester that owns the job. Only
// one job is ever in flight.
//   i_clk, i_arst      : clock, asynchronous active-high reset
//   i_req_valid        : per-requester job offer
//   o_req_ready        : per-requester accept, at most one bit set, IDLE only
//   i_req_a, i_req_b   : per-requester operand matrices
//   o_rsp_valid        : one-hot response valid towards the job owner
//   i_rsp_ready        : per-requester response accept (owner bit only used)
//   o_rsp_c            : product matrix, shared by all requesters
//   o_rsp_err          : 1 when the job timed out (o_rsp_c is then zero)
//   o_mul_a, o_mul_b   : operands held towards the multiplier
//   o_mul_validInput   : one-cycle launch pulse
//   i_mul_c            : multiplier result
//   i_mul_validResult  : multiplier result valid (also pulses spuriously)
//   o_busy             : controller is not IDLE
// ---------------------------------------------------------------------------
module systolic_job_arbiter
    import systolic_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  matrix_t [NUM_REQ-1:0] i_req_a,
    input  matrix_t [NUM_REQ-1:0] i_req_b,
    output logic [NUM_REQ-1:0]    o_rsp_valid,
    input  logic [NUM_REQ-1:0]    i_rsp_ready,
    output matrix_t               o_rsp_c,
    output logic                  o_rsp_err,
    output matrix_t               o_mul_a,
    output matrix_t               o_mul_b,
    output logic                  o_mul_validInput,
    input  matrix_t               i_mul_c,
    input  logic                  i_mul_validResult,
    output logic                  o_busy
);

    localparam int                    IW          = idx_width(NUM_REQ);
    localparam logic [IW-1:0]         LAST_RST    = IW'(NUM_REQ - 1);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

    state_t                  state_q;
    state_t                  state_d;
    logic [IW-1:0]           last_grant;
    logic [IW-1:0]           owner;
    logic [IW-1:0]           grant_idx;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      owner_onehot;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    req_hs;
    logic                    rsp_hs;
    logic                    result_hit;
    logic                    timeout_hit;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .req  (i_req_valid),
        .last (last_grant),
        .grant(grant)
    );

    // Ready is only offered while IDLE. It is also held low while reset is
    // asserted, because the state register reads IDLE during reset and the
    // arbiter would otherwise show a grant.
    assign o_req_ready = (state_q == IDLE && !i_arst) ? grant : '0;
    assign o_busy      = (state_q != IDLE);

    assign req_hs       = |(o_req_ready & i_req_valid);
    assign rsp_hs       = (state_q == RESP) && i_rsp_ready[owner];
    assign owner_onehot = NUM_REQ'(1) << owner;

    // A real result always beats the timeout when both land in one cycle.
    // Result pulses outside WAIT are strays from the free-running
    // multiplier and are deliberately ignored.
    assign result_hit  = (state_q == WAIT) && i_mul_validResult;
    assign timeout_hit = (state_q == WAIT) && !i_mul_validResult
                         && (wait_cnt == TIMEOUT_CNT);

    // Convert the one-hot grant into the index used for operand muxing,
    // ownership and round-robin history.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IW'(i);
            end
        end
    end

    // State register; reset drops any job in flight.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one job walks IDLE -> LAUNCH -> WAIT -> RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (result_hit || timeout_hit) state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request side: operands, owner and round-robin history only change on
    // a handshake, so the multiplier inputs stay stable for the whole job.
    // The launch pulse is the registered handshake, landing in LAUNCH.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_mul_a          <= '0;
            o_mul_b          <= '0;
            o_mul_validInput <= 1'b0;
            owner            <= '0;
            last_grant       <= LAST_RST;
        end else begin
            o_mul_validInput <= req_hs;
            if (req_hs) begin
                o_mul_a    <= i_req_a[grant_idx];
                o_mul_b    <= i_req_b[grant_idx];
                owner      <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    // Wait counter: cleared in LAUNCH so it reads 0 on the first WAIT
    // cycle, then counts every WAIT cycle. It never passes TIMEOUT because
    // the FSM leaves WAIT at that value.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wait_cnt <= '0;
        end else if (state_q == LAUNCH) begin
            wait_cnt <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        end
    end

    // Response side: product/error are captured once when leaving WAIT and
    // then held, untouched by stray result pulses, until the owner accepts.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_rsp_valid <= '0;
            o_rsp_c     <= '0;
            o_rsp_err   <= 1'b0;
        end else if (result_hit) begin
            o_rsp_valid <= owner_onehot;
            o_rsp_c     <= i_mul_c;
            o_rsp_err   <= 1'b0;
        end else if (timeout_hit) begin
            o_rsp_valid <= owner_onehot;
            o_rsp_c     <= '0;
            o_rsp_err   <= 1'b1;
        end else if (rsp_hs) begin
            o_rsp_valid <= '0;
        end
    end

endmodule

// File: doc/systolic_job_arbiter.md
# systolic_job_arbiter

Job controller in front of the 4x4 systolic matrix multiplier (`topSystolicArray`). Arbitrates round-robin between NUM_REQ requesters, each offering a pair of 4x4 int8 matrices on a valid/ready handshake. Captures the granted operands and launches the multiplier with a one-cycle `validInput` pulse. Waits for the first `validResult`, then returns the product to the originating requester on a valid/ready response channel. Only one job is in flight at a time.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT, 16, max WAIT cycles before abandoning a job (must exceed 11)

Ports:
- i_clk  in  1  clock
- i_arst  in  1  reset; asynchronous, active-high
- i_req_valid  in  NUM_REQ  per-requester job valid
- o_req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- i_req_a  in  NUM_REQ x [3:0][3:0][7:0]  operand A per requester
- i_req_b  in  NUM_REQ x [3:0][3:0][7:0]  operand B per requester
- o_rsp_valid  out  NUM_REQ  one-hot response valid to owning requester
- i_rsp_ready  in  NUM_REQ  per-requester response accept
- o_rsp_c  out  [3:0][3:0][7:0]  product, shared by all requesters
- o_rsp_err  out  1  response qualifier; 1 = timeout, o_rsp_c = 0
- o_mul_a, o_mul_b  out  [3:0][3:0][7:0]  operands to multiplier
- o_mul_validInput  out  1  launch pulse to multiplier
- i_mul_c  in  [3:0][3:0][7:0]  multiplier result
- i_mul_validResult  in  1  multiplier result valid
- o_busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE -> LAUNCH on a request handshake.
  - LAUNCH -> WAIT unconditionally.
  - WAIT -> RESP on i_mul_validResult, or on timeout.
  - RESP -> IDLE on a response handshake.
- Arbitration: round-robin, combinational in IDLE.
  - Search starts at requester (last_grant+1) mod NUM_REQ; the first with i_req_valid set is granted.
  - o_req_ready = grant when state==IDLE, else 0.
  - last_grant updates only on a handshake. Reset value is NUM_REQ-1, so requester 0 has first priority.
- On handshake: register the A/B operands into o_mul_a/o_mul_b and register the owner index. Operands are held stable until the next handshake.
- LAUNCH: o_mul_validInput=1 for exactly this cycle.
- WAIT:
  - 5-bit wait counter, cleared on entry, incremented each WAIT cycle.
  - First i_mul_validResult in WAIT: capture i_mul_c into o_rsp_c and set o_rsp_err=0.
  - Counter reaching TIMEOUT with no result: o_rsp_c=0, o_rsp_err=1.
- RESP: o_rsp_valid[owner]=1. o_rsp_c and o_rsp_err are held until i_rsp_ready[owner]. i_rsp_ready of non-owners is ignored.
- i_mul_validResult is ignored in IDLE, LAUNCH and RESP. The multiplier's free-running counter re-asserts validResult every 16 cycles, and those strays must not disturb state.
- Arithmetic: none. Product elements pass through unmodified (mod-256 truncation is the datapath's property).
- Reset values:
  - state IDLE
  - o_req_ready 0, o_rsp_valid 0, o_rsp_c 0, o_rsp_err 0
  - o_mul_a 0, o_mul_b 0, o_mul_validInput 0
  - o_busy 0, last_grant NUM_REQ-1
- Reset mid-job: the job is dropped, no response is issued, and the FSM returns to IDLE.

## Timing
- Request handshake at cycle t:
  - LAUNCH (o_mul_validInput=1) at t+1.
  - WAIT from t+2.
  - The multiplier raises validResult at t+12.
  - o_rsp_valid rises at t+13.
- Nominal request-to-response latency is 13 cycles. Timeout response is at t+2+TIMEOUT+1.
- Response handshake at cycle r: IDLE at r+1. The next request can be accepted at r+1 (minimum 14-cycle job period).
- o_req_ready is never asserted in the cycle a response handshakes.
- All outputs are registered except o_req_ready and o_busy, which are decoded from state.
- Simultaneous valid from all requesters: one grant per job, rotating, with no starvation. Worst-case wait is NUM_REQ-1 jobs.

## Structure
- Package systolic_ctrl_pkg:
  - typedef matrix_t = logic [3:0][3:0][7:0]
  - enum state_t {IDLE, LAUNCH, WAIT, RESP}
  - constant MUL_LATENCY = 11 (launch to validResult)
- Sub-module rr_arbiter: parameter N; inputs req[N], last[$clog2(N)]; output grant[N], one-hot or zero; purely combinational.
- Top-level FSM, wait counter, and operand/result registers live in systolic_job_arbiter.
- A bench wrapper instantiates systolic_job_arbiter plus topSystolicArray.

## Test plan
- Single job, requester 0: A = identity, B(r,c) = 4r+c -> o_rsp_valid[0] at t+13, o_rsp_c = B, o_rsp_err = 0.
- Contention: both requesters valid continuously, with distinct matrices -> grants alternate 0,1,0,1. Each response goes to the correct one-hot o_rsp_valid with the correct product.
- Backpressure: i_rsp_ready[0] low for 20 cycles -> o_rsp_valid/o_rsp_c stable, stray validResult pulses ignored, o_req_ready stays 0. Release -> IDLE next cycle.
- Stray results: i_mul_validResult forced high for 3 cycles while IDLE -> no state change, o_rsp_valid stays 0.
- Timeout: stub multiplier that never asserts validResult -> o_rsp_valid at t+19 (TIMEOUT=16), o_rsp_err = 1, o_rsp_c = 0.
- Reset in WAIT: assert i_arst at t+5 -> all outputs 0 the same cycle. After release, requester 0 regains first priority and no response is issued for the dropped job.
